// File: rtl/operand_fetch_stage_if.sv
// Bundles the fetch, register-file, writeback and execute-side signals of the operand fetch stage.
// slave = the stage itself; master = the surrounding pipeline (fetch, regfile, writeback, execute).
interface operand_fetch_stage_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_rb_sel;
  logic            in_wr_rd;
  logic            flush;
  logic [AW-1:0]   rf_rreg1;
  logic [AW-1:0]   rf_rreg2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            wb_regwrite;
  logic [AW-1:0]   wb_reg;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [AW-1:0]   out_rd;
  logic            out_wr_rd;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rb_sel, in_wr_rd, flush,
    input  rf_rdata1, rf_rdata2, wb_regwrite, wb_reg, wb_data, out_ready,
    output in_ready, rf_rreg1, rf_rreg2,
    output out_valid, out_pc, out_instr, out_a, out_b, out_rd, out_wr_rd
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rb_sel, in_wr_rd, flush,
    output rf_rdata1, rf_rdata2, wb_regwrite, wb_reg, wb_data, out_ready,
    input  in_ready, rf_rreg1, rf_rreg2,
    input  out_valid, out_pc, out_instr, out_a, out_b, out_rd, out_wr_rd
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand-read stage: regfile addressing, X31-reads-zero, scoreboard RAW stalls, output register.
// Define OPF_BYPASS_EN to forward same-cycle writeback data and release the stall in the writeback cycle.
module operand_fetch_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ZERO_REG = 31
) (
  input logic                clk,
  input logic                rst,
  operand_fetch_stage_if.slave bus
);

`ifdef OPF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int unsigned AW = $clog2(NREG);
  typedef logic [AW-1:0] reg_t;
  localparam reg_t ZERO = reg_t'(ZERO_REG);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  reg_t            rd_q, rd_d;
  logic            wr_q, wr_d;

  reg_t            rn, rb, rd;
  logic            wb_hit_a, wb_hit_b;
  logic            haz_a, haz_b, struct_stall;
  logic            accept, issue, inc_en, dec_en;
  logic [XLEN-1:0] op_a, op_b;

  // A pending count of exactly one that retires this cycle is covered by the bypass.
  function automatic logic busy(input logic [CNT_W-1:0] c, input logic wb_hit);
    return (c != '0) && !(BYPASS && (c == CNT_W'(1)) && wb_hit);
  endfunction

  assign rn = bus.in_instr[9:5];
  assign rb = bus.in_rb_sel ? bus.in_instr[4:0] : bus.in_instr[20:16];
  assign rd = bus.in_instr[4:0];

  assign bus.rf_rreg1 = rn;
  assign bus.rf_rreg2 = rb;

  assign wb_hit_a = bus.wb_regwrite && (bus.wb_reg == rn);
  assign wb_hit_b = bus.wb_regwrite && (bus.wb_reg == rb);

  assign haz_a = (rn != ZERO) && ((valid_q && wr_q && (rd_q == rn)) || busy(cnt_q[rn], wb_hit_a));
  assign haz_b = (rb != ZERO) && ((valid_q && wr_q && (rd_q == rb)) || busy(cnt_q[rb], wb_hit_b));
  assign struct_stall = bus.in_wr_rd && (cnt_q[rd] == '1);

  assign bus.in_ready = (!valid_q || bus.out_ready) && !haz_a && !haz_b && !struct_stall && !bus.flush;
  assign accept = bus.in_valid && bus.in_ready;
  assign issue  = valid_q && bus.out_ready;

  assign op_a = (rn == ZERO) ? '0 : (BYPASS && wb_hit_a) ? bus.wb_data : bus.rf_rdata1;
  assign op_b = (rb == ZERO) ? '0 : (BYPASS && wb_hit_b) ? bus.wb_data : bus.rf_rdata2;

  assign inc_en = issue && wr_q && (rd_q != ZERO);
  assign dec_en = bus.wb_regwrite && (bus.wb_reg != ZERO);

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((inc_en && (rd_q == reg_t'(i))) && !(dec_en && (bus.wb_reg == reg_t'(i))))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if ((dec_en && (bus.wb_reg == reg_t'(i))) && !(inc_en && (rd_q == reg_t'(i))))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  // Flush kills only the held slot; an issue in the same cycle has already been counted above.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = bus.in_pc;
      instr_d = bus.in_instr;
      a_d     = op_a;
      b_d     = op_b;
      rd_d    = rd;
      wr_d    = bus.in_wr_rd;
    end else if (issue) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_wr_rd = wr_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    dec_en |-> (cnt_q[bus.wb_reg] != '0));

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_operand_fetch_stage;
  localparam int XLEN = 64;

`ifdef OPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.XLEN(XLEN), .AW(5)) bus ();

  operand_fetch_stage #(.XLEN(XLEN), .NREG(32), .CNT_W(2), .ZERO_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] rf [32];
  assign bus.rf_rdata1 = rf[bus.rf_rreg1];
  assign bus.rf_rdata2 = rf[bus.rf_rreg2];

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        wr;
  } out_t;

  out_t        m;
  logic [4:0]  inflight[$];   // destinations issued to execute and not yet written back
  logic        rfw_en;
  logic [4:0]  rfw_reg;
  logic [63:0] rfw_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    return 32'h8B00_0000 | ({27'd0, rm} << 16) | ({27'd0, rn} << 5) | {27'd0, rd};
  endfunction

  function automatic int pend(input logic [4:0] r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] opval(input logic [4:0] src);
    if (src == 5'd31) return '0;
    if (BYP && bus.wb_regwrite && bus.wb_reg == src) return bus.wb_data;
    return rf[src];
  endfunction

  function automatic logic hazard(input logic [4:0] src);
    int p;
    if (src == 5'd31) return 1'b0;
    if (m.valid && m.wr && m.rd == src) return 1'b1;
    p = pend(src);
    if (BYP && bus.wb_regwrite && bus.wb_reg == src) p--;
    return p > 0;
  endfunction

  // Compare the DUT against the model, then advance the model across the coming edge.
  task automatic model_step();
    logic [4:0] rn, rb, rd;
    logic       exp_ready, issue, accept, wbreal;
    rn = bus.in_instr[9:5];
    rb = bus.in_rb_sel ? bus.in_instr[4:0] : bus.in_instr[20:16];
    rd = bus.in_instr[4:0];
    wbreal = bus.wb_regwrite && bus.wb_reg != 5'd31;
    exp_ready = (!m.valid || bus.out_ready) && !hazard(rn) && !hazard(rb) &&
                !(bus.in_wr_rd && pend(rd) >= 3) && !bus.flush;

    chk("out_valid", 64'(bus.out_valid), 64'(m.valid));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    chk("rf_rreg1", 64'(bus.rf_rreg1), 64'(rn));
    chk("rf_rreg2", 64'(bus.rf_rreg2), 64'(rb));
    if (m.valid) begin
      chk("out_pc", bus.out_pc, m.pc);
      chk("out_instr", 64'(bus.out_instr), 64'(m.instr));
      chk("out_a", bus.out_a, m.a);
      chk("out_b", bus.out_b, m.b);
      chk("out_rd", 64'(bus.out_rd), 64'(m.rd));
      chk("out_wr_rd", 64'(bus.out_wr_rd), 64'(m.wr));
    end

    issue  = m.valid && bus.out_ready;
    accept = bus.in_valid && exp_ready;
    if (wbreal) begin
      for (int i = 0; i < inflight.size(); i++)
        if (inflight[i] == bus.wb_reg) begin inflight.delete(i); break; end
    end
    if (issue && m.wr && m.rd != 5'd31) inflight.push_back(m.rd);
    rfw_en   = bus.wb_regwrite;
    rfw_reg  = bus.wb_reg;
    rfw_data = bus.wb_data;
    if (bus.flush) m.valid = 1'b0;
    else if (accept) begin
      m.valid = 1'b1;
      m.pc    = bus.in_pc;
      m.instr = bus.in_instr;
      m.a     = opval(rn);
      m.b     = opval(rb);
      m.rd    = rd;
      m.wr    = bus.in_wr_rd;
    end else if (issue) m.valid = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (rfw_en) rf[rfw_reg] = rfw_data;
    rfw_en = 1'b0;
    bus.wb_regwrite = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic present(input logic [31:0] instr, input logic [63:0] pc, input logic rb_sel, input logic wr);
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.in_rb_sel = rb_sel;
    bus.in_wr_rd  = wr;
  endtask

  task automatic set_wb(input logic [4:0] r, input logic [63:0] d);
    bus.wb_regwrite = 1'b1;
    bus.wb_reg      = r;
    bus.wb_data     = d;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!m.valid && inflight.size() == 0) break;
      if (inflight.size() != 0) set_wb(inflight[0], {$urandom, $urandom});
      cycle();
    end
  endtask

  task automatic model_reset();
    m = '0;
    inflight.delete();
    rfw_en = 1'b0;
  endtask

  initial begin
    int acc;
    logic rdy;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.in_rb_sel = 1'b0;
    bus.in_wr_rd = 1'b0; bus.flush = 1'b0; bus.wb_regwrite = 1'b0; bus.wb_reg = '0;
    bus.wb_data = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_a", bus.out_a, 64'd0);
    chk("rst_out_b", bus.out_b, 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_wr_rd", 64'(bus.out_wr_rd), 64'd0);
    rst = 1'b1;

    // ADD X1,X2,X3 then ADD X4,X1,X1 with X1 written back two cycles after the dependent shows up
    present(enc(5'd1, 5'd2, 5'd3), 64'h100, 1'b0, 1'b1);
    #1 chk("add1_ready", 64'(bus.in_ready), 64'd1);
    cycle();
    present(enc(5'd4, 5'd1, 5'd1), 64'h104, 1'b0, 1'b1);
    acc = -1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) set_wb(5'd1, 64'h2A);
      #1 rdy = bus.in_ready;
      cycle();
      if (rdy) begin acc = k; break; end
    end
    bus.in_valid = 1'b0;
    chk("raw_accept_cycle", 64'(acc), BYP ? 64'd2 : 64'd3);
    chk("raw_out_a", bus.out_a, 64'h2A);
    chk("raw_out_b", bus.out_b, 64'h2A);
    drain();

    // X31 reads zero even when written back, and is never tracked
    rf[31] = 64'hDEAD;
    present(enc(5'd0, 5'd31, 5'd2), 64'h180, 1'b0, 1'b0);
    set_wb(5'd31, 64'h55);
    #1 chk("x31_ready", 64'(bus.in_ready), 64'd1);
    cycle();
    chk("x31_out_a", bus.out_a, 64'd0);
    present(enc(5'd0, 5'd31, 5'd31), 64'h184, 1'b0, 1'b0);
    #1 chk("x31_untracked", 64'(bus.in_ready), 64'd1);
    cycle();
    drain();

    // Execute back-pressure for 5 cycles
    bus.out_ready = 1'b0;
    present(enc(5'd6, 5'd0, 5'd0), 64'h200, 1'b0, 1'b1);
    cycle();
    present(enc(5'd8, 5'd0, 5'd0), 64'h204, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("hold_ready", 64'(bus.in_ready), 64'd0);
      cycle();
      chk("hold_out_pc", bus.out_pc, 64'h200);
    end
    drain();

    // Three issued X7 writers saturate the counter; the fourth waits for one writeback
    for (int k = 0; k < 3; k++) begin
      present(enc(5'd7, 5'd0, 5'd0), 64'h300 + 64'(4 * k), 1'b0, 1'b1);
      #1 chk("x7_writer_ready", 64'(bus.in_ready), 64'd1);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    present(enc(5'd7, 5'd0, 5'd0), 64'h30C, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1 chk("struct_stall", 64'(bus.in_ready), 64'd0);
      cycle();
    end
    set_wb(5'd7, 64'h77);
    #1 chk("struct_wb_cycle", 64'(bus.in_ready), 64'd0);
    cycle();
    #1 chk("struct_release", 64'(bus.in_ready), 64'd1);
    cycle();
    drain();

    // Flush a held X5 writer after one X5 writer has issued
    present(enc(5'd5, 5'd0, 5'd0), 64'h400, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    present(enc(5'd5, 5'd0, 5'd0), 64'h404, 1'b0, 1'b1);
    cycle();
    present(enc(5'd10, 5'd0, 5'd0), 64'h408, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1 chk("flush_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    chk("flush_kill", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_wb(5'd5, 64'h5555);
    cycle();
    present(enc(5'd11, 5'd5, 5'd5), 64'h40C, 1'b0, 1'b0);
    #1 chk("flush_cnt", 64'(bus.in_ready), 64'd1);
    cycle();
    drain();

    // Reset with a held instruction and two X3 writes pending
    present(enc(5'd3, 5'd0, 5'd0), 64'h500, 1'b0, 1'b1);
    cycle();
    present(enc(5'd3, 5'd0, 5'd0), 64'h504, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    present(enc(5'd3, 5'd0, 5'd0), 64'h508, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_out_a", bus.out_a, 64'd0);
    chk("rst_mid_out_rd", 64'(bus.out_rd), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    present(enc(5'd12, 5'd3, 5'd3), 64'h600, 1'b0, 1'b0);
    #1 chk("rst_cnt_clear", 64'(bus.in_ready), 64'd1);
    cycle();
    drain();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] instr;
      logic [4:0]  r [3];
      logic        wr;
      for (int j = 0; j < 3; j++) begin
        r[j] = 5'($urandom_range(0, 8));
        if (r[j] == 5'd8) r[j] = 5'd31;
      end
      instr = $urandom;
      instr[4:0] = r[0];
      instr[9:5] = r[1];
      instr[20:16] = r[2];
      wr = 1'($urandom_range(0, 1));
      if (wr && r[0] != 5'd31 && pend(r[0]) < 3 &&
          pend(r[0]) + ((m.valid && m.wr && m.rd == r[0]) ? 1 : 0) >= 3)
        wr = 1'b0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      if (inflight.size() != 0 && $urandom_range(0, 2) == 0) set_wb(inflight[0], {$urandom, $urandom});
      else if ($urandom_range(0, 15) == 0) set_wb(5'd31, {$urandom, $urandom});
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = instr;
      bus.in_pc     = {$urandom, $urandom};
      bus.in_rb_sel = 1'($urandom_range(0, 1));
      bus.in_wr_rd  = wr;
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
